// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings and FSM state type shared by the wait-state SRAM slave.
`default_nettype none

package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    // True when the byte address is not a multiple of the transfer size.
    function automatic logic misaligned(input logic [7:0] addr_lo, input logic [2:0] size);
        logic [7:0] mask;
        mask = (8'd1 << size) - 8'd1;
        return (addr_lo & mask) != 8'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_sram_array.sv
// ahb_sram_array: WORDS x AHBW storage with per-byte write enables and
// asynchronous read; contents are intentionally never reset.
`default_nettype none

module ahb_sram_array #(
    parameter int WORDS = 4096,
    parameter int AHBW  = 64,
    parameter int IDX_W = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [AHBW/8-1:0] strb,
    input  logic [AHBW-1:0]   wdata,
    output logic [AHBW-1:0]   rdata
);

    logic [AHBW-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < AHBW / 8; b++) begin
                if (strb[b]) begin
                    mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

`default_nettype wire

// File: rtl/ahb_wait_sram.sv
// ahb_wait_sram: AHB-Lite memory slave with programmable wait states and a
// two-cycle ERROR response for out-of-window or misaligned transfers.
`default_nettype none

module ahb_wait_sram
    import ahb_pkg::*;
#(
    parameter int                 PA_BITS     = 56,
    parameter int                 AHBW        = 64,
    parameter logic [PA_BITS-1:0] BASE        = 56'h0000_8000_0000,
    parameter int                 WORDS       = 4096,
    parameter int                 WAIT_STATES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               HSEL,
    input  logic [PA_BITS-1:0] HADDR,
    input  logic [1:0]         HTRANS,
    input  logic               HWRITE,
    input  logic [2:0]         HSIZE,
    input  logic [2:0]         HBURST,
    input  logic [AHBW/8-1:0]  HWSTRB,
    input  logic [AHBW-1:0]    HWDATA,
    input  logic               HREADY,
    output logic [AHBW-1:0]    HRDATA,
    output logic               HREADYOUT,
    output logic               HRESP
);

    localparam int BYTES = AHBW / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [PA_BITS:0] LIMIT = {1'b0, BASE} + (PA_BITS+1)'(WORDS * BYTES);

    state_t             state, state_next;
    logic [3:0]         wait_cnt, wait_cnt_next;
    logic [IDX_W-1:0]   idx_q;
    logic               write_q;
    logic               ready_state;
    logic               accept;
    logic               in_range;
    logic               addr_err;
    logic [PA_BITS-1:0] offset;
    logic               mem_we;
    logic [AHBW-1:0]    rdata;
    logic               unused_bits;

    assign ready_state = (state != S_WAIT) && (state != S_ERR1);
    assign accept      = ready_state && HSEL && HREADY && HTRANS[1];

    assign in_range = ({1'b0, HADDR} >= {1'b0, BASE}) && ({1'b0, HADDR} < LIMIT);
    assign addr_err = !in_range || (HSIZE > 3'(OFF_W)) || misaligned(HADDR[7:0], HSIZE);
    assign offset   = HADDR - BASE;

    // Burst type carries no meaning here; only low offset bits feed the index.
    assign unused_bits = ^{HBURST, offset};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (accept) begin
                idx_q   <= offset[OFF_W +: IDX_W];
                write_q <= HWRITE;
            end
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        HREADYOUT     = 1'b1;
        HRESP         = HRESP_OKAY;
        mem_we        = 1'b0;
        case (state)
            S_WAIT: begin
                HREADYOUT = 1'b0;
                if (wait_cnt == 4'd0) begin
                    state_next = S_DATA;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            S_ERR1: begin
                HREADYOUT  = 1'b0;
                HRESP      = HRESP_ERROR;
                state_next = S_ERR2;
            end
            default: begin
                // IDLE, DATA and ERR2 all complete with HREADYOUT high and may take a new address phase.
                if (state == S_DATA) begin
                    mem_we = write_q;
                end
                if (state == S_ERR2) begin
                    HRESP = HRESP_ERROR;
                end
                if (!accept) begin
                    state_next = S_IDLE;
                end else if (addr_err) begin
                    state_next = S_ERR1;
                end else if (WAIT_STATES == 0) begin
                    state_next = S_DATA;
                end else begin
                    state_next    = S_WAIT;
                    wait_cnt_next = 4'(WAIT_STATES - 1);
                end
            end
        endcase
    end

    ahb_sram_array #(
        .WORDS (WORDS),
        .AHBW  (AHBW),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we && !reset),
        .idx   (idx_q),
        .strb  (HWSTRB),
        .wdata (HWDATA),
        .rdata (rdata)
    );

    assign HRDATA = (state == S_DATA && !write_q) ? rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_ahb_wait_sram.sv
// tb_ahb_wait_sram: directed vector table, hand sequences and a randomized pipelined
// master checked against a transaction-level memory model, on WAIT_STATES=2 and 0.
`default_nettype none

module tb_ahb_wait_sram;

    localparam logic [55:0] BASE  = 56'h0000_8000_0000;
    localparam int          WORDS = 4096;
    localparam logic [55:0] TOP   = BASE + 56'(WORDS * 8);

    logic        clk = 1'b0;
    logic        reset;
    logic        hsel      [2];
    logic [55:0] haddr     [2];
    logic [1:0]  htrans    [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [2:0]  hburst    [2];
    logic [7:0]  hwstrb    [2];
    logic [63:0] hwdata    [2];
    logic        hready    [2];
    logic [63:0] hrdata    [2];
    logic        hreadyout [2];
    logic        hresp     [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ahb_wait_sram #(.WAIT_STATES(2)) dut_ws2 (
        .clk(clk), .reset(reset), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]), .HWSTRB(hwstrb[0]),
        .HWDATA(hwdata[0]), .HREADY(hready[0]), .HRDATA(hrdata[0]),
        .HREADYOUT(hreadyout[0]), .HRESP(hresp[0])
    );

    ahb_wait_sram #(.WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .reset(reset), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]), .HWSTRB(hwstrb[1]),
        .HWDATA(hwdata[1]), .HREADY(hready[1]), .HRDATA(hrdata[1]),
        .HREADYOUT(hreadyout[1]), .HRESP(hresp[1])
    );

    typedef struct {
        logic        wr;
        logic [55:0] addr;
        logic [2:0]  size;
        logic [7:0]  strb;
        logic [63:0] data;
        int          waits;
        logic        resp;
        logic [63:0] rdata;
    } vec_t;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [55:0] addr;
        logic [2:0]  size;
        logic [7:0]  strb;
        logic [63:0] data;
    } txn_t;

    logic [63:0] mem_m [2][16];

    function automatic int ws_of(input int inst);
        return (inst == 0) ? 2 : 0;
    endfunction

    function automatic bit model_err(input logic [55:0] a, input logic [2:0] sz);
        if (a < BASE || a >= TOP) return 1'b1;
        if (sz > 3'd3) return 1'b1;
        return (a % (56'd1 << sz)) != 56'd0;
    endfunction

    function automatic int slot_of(input logic [55:0] a);
        int w;
        w = int'((a - BASE) / 56'd8);
        return (w < 8) ? w : w - (WORDS - 16);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic bus_idle(input int i);
        hsel[i]   = 1'b0;
        htrans[i] = 2'b00;
        hwrite[i] = 1'b0;
        haddr[i]  = '0;
        hsize[i]  = 3'd3;
    endtask

    task automatic addr_phase(input int i, input logic w, input logic [55:0] a, input logic [2:0] sz);
        hsel[i]   = 1'b1;
        htrans[i] = 2'b10;
        hwrite[i] = w;
        haddr[i]  = a;
        hsize[i]  = sz;
        hready[i] = 1'b1;
    endtask

    // Single non-pipelined transfer; write data is garbage until the completing cycle.
    task automatic xfer(input int i, input logic w, input logic [55:0] a, input logic [2:0] sz,
                        input logic [7:0] st, input logic [63:0] d,
                        output int waits, output logic resp, output logic [63:0] rd);
        addr_phase(i, w, a, sz);
        step();
        bus_idle(i);
        hwdata[i] = ~d;
        hwstrb[i] = ~st;
        waits = 0;
        while (!hreadyout[i] && waits < 40) begin
            waits++;
            hready[i] = 1'b0;
            step();
        end
        hready[i] = 1'b1;
        chk("xfer_ready", 64'(hreadyout[i]), 64'd1);
        hwdata[i] = d;
        hwstrb[i] = st;
        resp = hresp[i];
        rd   = hrdata[i];
        step();
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        int r, k, w;
        t.sel   = 1'b1;
        t.trans = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
        r = int'($urandom_range(0, 99));
        if (r < 12) begin
            t.sel   = ($urandom_range(0, 1) != 0);
            t.trans = t.sel ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
        end
        t.wr   = ($urandom_range(0, 1) != 0);
        t.size = 3'($urandom_range(0, 3));
        t.strb = 8'($urandom);
        t.data = {$urandom, $urandom};
        k = int'($urandom_range(0, 15));
        w = (k < 8) ? k : WORDS - 16 + k;
        t.addr = BASE + 56'(w * 8);
        r = int'($urandom_range(0, 99));
        if (r < 8)       t.addr = TOP + 56'($urandom_range(0, 3) * 8);
        else if (r < 14) t.addr = BASE - 56'(8 * $urandom_range(1, 4));
        else if (r < 24) t.addr = t.addr + 56'($urandom_range(0, 7));
        else             t.addr = t.addr + 56'((($urandom_range(0, 7)) >> t.size) << t.size);
        return t;
    endfunction

    // Pipelined master: next address phase is presented in every ready cycle.
    task automatic run_random(input int i, input int n);
        txn_t q[$];
        txn_t t, dp;
        bit   dp_v;
        int   dp_waits, k, cyc, s;
        logic e;
        logic [63:0] m;
        for (int j = 0; j < 16; j++) begin
            t.sel = 1'b1; t.trans = 2'b10; t.wr = 1'b1; t.size = 3'd3; t.strb = 8'hFF;
            t.data = {$urandom, $urandom};
            t.addr = BASE + 56'(((j < 8) ? j : WORDS - 16 + j) * 8);
            q.push_back(t);
        end
        for (int j = 0; j < n; j++) q.push_back(rand_txn());
        dp_v = 1'b0; dp_waits = 0; k = 0; cyc = 0;
        while ((k < q.size() || dp_v) && cyc < 20000) begin
            cyc++;
            hready[i] = hreadyout[i];
            if (hreadyout[i]) begin
                hwdata[i] = {$urandom, $urandom};
                hwstrb[i] = 8'($urandom);
                if (dp_v) begin
                    e = model_err(dp.addr, dp.size);
                    hwdata[i] = dp.data;
                    hwstrb[i] = dp.strb;
                    chk("rnd_waits", 64'(dp_waits), e ? 64'd1 : 64'(ws_of(i)));
                    chk("rnd_resp", 64'(hresp[i]), 64'(e));
                    s = e ? 0 : slot_of(dp.addr);
                    chk("rnd_rdata", hrdata[i], (!e && !dp.wr) ? mem_m[i][s] : 64'd0);
                    if (!e && dp.wr) begin
                        m = mem_m[i][s];
                        for (int b = 0; b < 8; b++)
                            if (dp.strb[b]) m[b*8 +: 8] = dp.data[b*8 +: 8];
                        mem_m[i][s] = m;
                    end
                    dp_v = 1'b0;
                end else begin
                    chk("rnd_idle_resp", 64'(hresp[i]), 64'd0);
                    chk("rnd_idle_rdata", hrdata[i], 64'd0);
                end
                if (k < q.size()) begin
                    t = q[k];
                    k++;
                    hsel[i] = t.sel; htrans[i] = t.trans; hwrite[i] = t.wr;
                    haddr[i] = t.addr; hsize[i] = t.size;
                    if (t.sel && t.trans[1]) begin
                        dp = t; dp_v = 1'b1; dp_waits = 0;
                    end
                end else begin
                    bus_idle(i);
                end
            end else begin
                if (!dp_v) begin
                    chk("rnd_unexpected_stall", 64'(hreadyout[i]), 64'd1);
                end else begin
                    dp_waits++;
                    chk("rnd_stall_resp", 64'(hresp[i]), 64'(model_err(dp.addr, dp.size)));
                    chk("rnd_stall_rdata", hrdata[i], 64'd0);
                end
                hsel[i] = 1'b1; htrans[i] = 2'b10; hwrite[i] = 1'b1;
                haddr[i] = BASE + 56'($urandom_range(0, 7) * 8); hsize[i] = 3'd3;
                hwdata[i] = {$urandom, $urandom};
                hwstrb[i] = 8'($urandom);
            end
            step();
        end
        chk("rnd_completed", 64'(k + (dp_v ? 1 : 0)), 64'(q.size()));
        bus_idle(i);
        hready[i] = 1'b1;
        step();
    endtask

    vec_t vt [13];

    initial begin
        int          waits;
        logic        resp;
        logic [63:0] rd;

        vt[0]  = '{1'b1, BASE,        3'd3, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 2, 1'b0, 64'h0};
        vt[1]  = '{1'b0, BASE,        3'd3, 8'h00, 64'h0,                   2, 1'b0, 64'hDEAD_BEEF_CAFE_F00D};
        vt[2]  = '{1'b1, BASE + 16,   3'd3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b0, 64'h0};
        vt[3]  = '{1'b1, BASE + 16,   3'd3, 8'h0F, 64'h0,                   2, 1'b0, 64'h0};
        vt[4]  = '{1'b0, BASE + 16,   3'd3, 8'h00, 64'h0,                   2, 1'b0, 64'hFFFF_FFFF_0000_0000};
        vt[5]  = '{1'b0, TOP,         3'd3, 8'h00, 64'h0,                   1, 1'b1, 64'h0};
        vt[6]  = '{1'b0, BASE + 2,    3'd2, 8'h00, 64'h0,                   1, 1'b1, 64'h0};
        vt[7]  = '{1'b0, BASE - 8,    3'd3, 8'h00, 64'h0,                   1, 1'b1, 64'h0};
        vt[8]  = '{1'b1, TOP - 8,     3'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, 2, 1'b0, 64'h0};
        vt[9]  = '{1'b0, TOP - 8,     3'd3, 8'h00, 64'h0,                   2, 1'b0, 64'h0123_4567_89AB_CDEF};
        vt[10] = '{1'b0, BASE + 4,    3'd2, 8'h00, 64'h0,                   2, 1'b0, 64'hDEAD_BEEF_CAFE_F00D};
        vt[11] = '{1'b1, BASE + 3,    3'd1, 8'hFF, 64'h0,                   1, 1'b1, 64'h0};
        vt[12] = '{1'b0, BASE,        3'd3, 8'h00, 64'h0,                   2, 1'b0, 64'hDEAD_BEEF_CAFE_F00D};

        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus_idle(i);
            hready[i] = 1'b1;
            hburst[i] = 3'($urandom);
            hwstrb[i] = 8'h00;
            hwdata[i] = 64'h0;
        end
        repeat (3) step();
        for (int i = 0; i < 2; i++) begin
            chk("reset_hreadyout", 64'(hreadyout[i]), 64'd1);
            chk("reset_hresp", 64'(hresp[i]), 64'd0);
            chk("reset_hrdata", hrdata[i], 64'd0);
        end
        reset = 1'b0;
        step();

        for (int v = 0; v < 13; v++) begin
            xfer(0, vt[v].wr, vt[v].addr, vt[v].size, vt[v].strb, vt[v].data, waits, resp, rd);
            chk($sformatf("vec%0d_waits", v), 64'(waits), 64'(vt[v].waits));
            chk($sformatf("vec%0d_resp", v), 64'(resp), 64'(vt[v].resp));
            chk($sformatf("vec%0d_rdata", v), rd, vt[v].rdata);
        end

        // Back-to-back write then read of the same word with no wait states.
        addr_phase(1, 1'b1, BASE + 8, 3'd3);
        step();
        chk("b2b_write_ready", 64'(hreadyout[1]), 64'd1);
        hwdata[1] = 64'h1111;
        hwstrb[1] = 8'hFF;
        addr_phase(1, 1'b0, BASE + 8, 3'd3);
        step();
        bus_idle(1);
        chk("b2b_read_ready", 64'(hreadyout[1]), 64'd1);
        chk("b2b_read_resp", 64'(hresp[1]), 64'd0);
        chk("b2b_read_data", hrdata[1], 64'h1111);
        step();

        // Error response followed by a NONSEQ accepted during its second cycle.
        addr_phase(0, 1'b0, TOP, 3'd3);
        step();
        bus_idle(0);
        hready[0] = 1'b0;
        chk("err1_ready", 64'(hreadyout[0]), 64'd0);
        chk("err1_resp", 64'(hresp[0]), 64'd1);
        step();
        chk("err2_ready", 64'(hreadyout[0]), 64'd1);
        chk("err2_resp", 64'(hresp[0]), 64'd1);
        addr_phase(0, 1'b0, BASE, 3'd3);
        step();
        bus_idle(0);
        hready[0] = 1'b0;
        chk("after_err_w1_ready", 64'(hreadyout[0]), 64'd0);
        chk("after_err_w1_resp", 64'(hresp[0]), 64'd0);
        step();
        chk("after_err_w2_ready", 64'(hreadyout[0]), 64'd0);
        step();
        hready[0] = 1'b1;
        chk("after_err_data_ready", 64'(hreadyout[0]), 64'd1);
        chk("after_err_data_resp", 64'(hresp[0]), 64'd0);
        chk("after_err_data", hrdata[0], 64'hDEAD_BEEF_CAFE_F00D);
        step();

        // Reset in the second wait cycle of a write drops the write.
        addr_phase(0, 1'b1, BASE, 3'd3);
        step();
        bus_idle(0);
        hready[0] = 1'b0;
        hwdata[0] = 64'hABCD;
        hwstrb[0] = 8'hFF;
        step();
        reset = 1'b1;
        step();
        chk("rst_mid_ready", 64'(hreadyout[0]), 64'd1);
        chk("rst_mid_resp", 64'(hresp[0]), 64'd0);
        chk("rst_mid_rdata", hrdata[0], 64'd0);
        reset = 1'b0;
        hready[0] = 1'b1;
        step();
        xfer(0, 1'b0, BASE, 3'd3, 8'h00, 64'h0, waits, resp, rd);
        chk("rst_mid_old_data", rd, 64'hDEAD_BEEF_CAFE_F00D);

        // BUSY and IDLE with HSEL, and NONSEQ with HREADY low: no transfer.
        for (int c = 0; c < 3; c++) begin
            hsel[0] = 1'b1; hwrite[0] = 1'b1; haddr[0] = BASE; hsize[0] = 3'd3;
            htrans[0] = (c == 0) ? 2'b01 : ((c == 1) ? 2'b00 : 2'b10);
            hready[0] = (c != 2);
            hwdata[0] = 64'h0;
            hwstrb[0] = 8'hFF;
            step();
            bus_idle(0);
            hready[0] = 1'b1;
            chk($sformatf("notx%0d_ready", c), 64'(hreadyout[0]), 64'd1);
            chk($sformatf("notx%0d_resp", c), 64'(hresp[0]), 64'd0);
            chk($sformatf("notx%0d_rdata", c), hrdata[0], 64'd0);
            step();
        end
        xfer(0, 1'b0, BASE, 3'd3, 8'h00, 64'h0, waits, resp, rd);
        chk("notx_waits", 64'(waits), 64'd2);
        chk("notx_unchanged", rd, 64'hDEAD_BEEF_CAFE_F00D);

        run_random(0, 300);
        run_random(1, 300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ahb_wait_sram.md
# ahb_wait_sram

AHB-Lite slave memory that sits directly downstream of the Wally core's AHB master port. It consumes HADDR/HTRANS/HWRITE/HSIZE/HWSTRB/HWDATA and returns HRDATA/HREADYOUT/HRESP. It provides a byte-strobed word array with a programmable number of wait states and a protocol-correct two-cycle ERROR response. It is the default backing store for core bring-up and for stall-path stress testing.

## Interface
- PA_BITS, 56, physical address width (matches core HADDR)
- AHBW, 64, data bus width; word = AHBW/8 bytes
- BASE, 56'h0000_8000_0000, byte base address of the array
- WORDS, 4096, array depth in AHBW-bit words (power of two)
- WAIT_STATES, 2, HREADYOUT-low cycles inserted per OKAY data phase (0..15)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- HSEL  in  1  slave select
- HADDR  in  PA_BITS  byte address
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size, log2 bytes (0..3)
- HBURST  in  3  ignored; every beat is handled independently
- HWSTRB  in  AHBW/8  byte enables, sampled in the data phase
- HWDATA  in  AHBW  write data, sampled in the data phase
- HREADY  in  1  bus HREADY; qualifies address-phase sampling
- HRDATA  out  AHBW  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR

## Operation
- Accept an address phase when HSEL & HTRANS[1] & HREADY. Register the address, HWRITE and HSIZE, and compute err_q.
- err_q is set if either condition holds:
  - HADDR < BASE, or HADDR >= BASE + WORDS*AHBW/8.
  - HADDR is not aligned to 2^HSIZE bytes.
- Word index = (HADDR - BASE) >> log2(AHBW/8).
- IDLE or BUSY with HSEL, or HSEL low: no transfer. The next cycle gives HREADYOUT=1, HRESP=0.
- FSM states:
  - IDLE: a valid accept with !err goes to WAIT if WAIT_STATES>0, else to DATA. A valid accept with err goes to ERR1.
  - WAIT: wait counter loads WAIT_STATES-1 on accept and decrements each cycle. HREADYOUT=0, HRESP=0. Go to DATA when the counter reaches 0.
  - DATA: HREADYOUT=1, HRESP=0.
    - Write: mem[idx] bytes with HWSTRB=1 are updated from HWDATA at the end of this cycle.
    - Read: HRDATA = mem[idx], read from the registered index.
    - A new address phase accepted in this cycle goes directly to WAIT, DATA or ERR1. No bubble.
  - ERR1: HREADYOUT=0, HRESP=1. Always goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. An address phase accepted here is processed normally. The ERROR transfer performs no memory access.
- HRDATA is 0 in every cycle that is not a read DATA cycle.
- Read-after-write to the same address, back-to-back: the write commits at the edge that captures the read's address phase, so the read returns the new data. No forwarding logic is needed.
- Reset mid-transfer returns the FSM to IDLE. A pending write is dropped and the array is not modified.
- Array contents are not reset.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, counter=0.
- OKAY latency: the data phase completes WAIT_STATES+1 cycles after the address-phase edge.
- ERROR latency: always exactly 2 cycles (ERR1, ERR2), independent of WAIT_STATES.
- Pipelined throughput with WAIT_STATES=0: one transfer per cycle.
- HWDATA and HWSTRB are used only in the DATA cycle. Values presented during WAIT are ignored.
- Address-phase signals are ignored whenever HREADY=0.

## Structure
- Shared package ahb_pkg:
  - HTRANS encodings (HTRANS_IDLE/BUSY/NONSEQ/SEQ).
  - HRESP_OKAY/HRESP_ERROR.
  - The FSM state enum {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2}.
- Sub-module ahb_sram_array: WORDS x AHBW array with byte-enable write, asynchronous read by index, and no reset.
- Top level holds the FSM, wait counter, address decode and alignment check.

## Test plan
- WAIT_STATES=2: write 64'hDEAD_BEEF_CAFE_F00D to BASE with strobe 8'hFF, then read BASE.
  - Required: HREADYOUT low for 2 cycles on each transfer, then the read returns 64'hDEAD_BEEF_CAFE_F00D with HRESP=0.
- WAIT_STATES=0: back-to-back write of 64'h1111 to BASE+8 followed immediately by a read of BASE+8.
  - Required: the read returns 64'h1111, with no HREADYOUT low cycle.
- Byte strobe: write 64'hFFFF_FFFF_FFFF_FFFF, then write 64'h0 with HWSTRB=8'h0F, then read.
  - Required: 64'hFFFF_FFFF_0000_0000.
- Read of BASE+WORDS*8, and a 4-byte read (HSIZE=2) at BASE+2.
  - Required for each: cycle 1 gives HREADYOUT=0, HRESP=1; cycle 2 gives HREADYOUT=1, HRESP=1.
  - A NONSEQ accepted during ERR2 completes OKAY.
- Assert reset in the second WAIT cycle of a write of 64'hABCD.
  - Required: the next cycle shows HREADYOUT=1, HRESP=0, HRDATA=0, and a subsequent read shows the old contents.
- Drive HTRANS=BUSY and IDLE with HSEL=1, and drive NONSEQ with HREADY=0.
  - Required: no state change, HREADYOUT stays 1, and the array is unchanged.
